piarb_buf_writer: RTL

//  Write-side front end of the PIARB shared packet memory. Owns the free list of buffer pointers and

---
 rtl/piarb_buf_writer.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/piarb_buf_writer.sv
// Write-side front end of the PIARB packet memory: owns the free list of buffer pointers,
// chops incoming packet words into fixed-size buffers and emits one descriptor per closed buffer.
module piarb_buf_writer #(
  parameter int BPTR_NBITS     = 3,
  parameter int BPTR_LSB_NBITS = 2,
  parameter int DATA_NBITS     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [DATA_NBITS-1:0]     in_data,
  input  logic                      rel_buf_valid,
  input  logic [BPTR_NBITS-1:0]     rel_buf_ptr,
  output logic                      write_data_valid,
  output logic [BPTR_NBITS-1:0]     write_buf_ptr,
  output logic [BPTR_LSB_NBITS-1:0] write_buf_ptr_lsb,
  output logic [DATA_NBITS-1:0]     write_data,
  output logic                      desc_valid,
  output logic [BPTR_NBITS-1:0]     desc_buf_ptr,
  output logic                      desc_sop,
  output logic                      desc_eop,
  output logic [BPTR_LSB_NBITS-1:0] desc_last_lsb,
  output logic [BPTR_NBITS:0]       free_count,
  output logic                      init_done,
  output logic                      err_protocol,
  output logic                      err_overflow
);

  localparam int NBUF = 2**BPTR_NBITS;

  typedef logic [BPTR_NBITS-1:0]     ptr_t;
  typedef logic [BPTR_LSB_NBITS-1:0] lsb_t;
  typedef logic [BPTR_NBITS:0]       cnt_t;
  typedef logic [DATA_NBITS-1:0]     data_t;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_OPEN} state_e;

  typedef struct packed {
    logic valid;
    ptr_t ptr;
    logic sop;
    logic eop;
    lsb_t last_lsb;
  } desc_t;

  state_e state_q, state_d;
  ptr_t   head_q, head_d, tail_q, tail_d;
  cnt_t   count_q, count_d;
  logic   init_done_q, init_done_d;
  ptr_t   cur_ptr_q, cur_ptr_d;
  lsb_t   lsb_q, lsb_d;
  logic   buf_sop_q, buf_sop_d;
  logic   wr_valid_q, wr_valid_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  lsb_t   wr_lsb_q, wr_lsb_d;
  data_t  wr_data_q, wr_data_d;
  desc_t  desc_q, desc_d;
  desc_t  pend_q, pend_d;
  logic   err_protocol_q, err_protocol_d;
  logic   err_overflow_q, err_overflow_d;

  ptr_t   fl_mem [NBUF];
  logic   fl_we;
  ptr_t   fl_waddr, fl_wdata;

  logic   accept, pop, push;
  ptr_t   word_ptr;
  lsb_t   word_lsb;
  logic   word_sop;
  desc_t  closing;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
    state_d        = state_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    init_done_d    = init_done_q;
    cur_ptr_d      = cur_ptr_q;
    lsb_d          = lsb_q;
    buf_sop_d      = buf_sop_q;
    wr_valid_d     = 1'b0;
    wr_ptr_d       = wr_ptr_q;
    wr_lsb_d       = wr_lsb_q;
    wr_data_d      = wr_data_q;
    desc_d         = pend_q;
    pend_d         = '0;
    err_protocol_d = err_protocol_q;
    err_overflow_d = err_overflow_q;
    fl_we          = 1'b0;
    fl_waddr       = tail_q;
    fl_wdata       = rel_buf_ptr;
    in_ready       = 1'b0;
    pop            = 1'b0;
    push           = 1'b0;
    word_ptr       = cur_ptr_q;
    word_lsb       = lsb_t'(lsb_q + 1'b1);
    word_sop       = buf_sop_q;
    closing        = '0;

    unique case (state_q)
      S_INIT: begin
        fl_we    = 1'b1;
        fl_wdata = tail_q;
        tail_d   = ptr_t'(tail_q + 1'b1);
        if (tail_q == ptr_t'(NBUF - 1)) begin
          init_done_d = 1'b1;
          count_d     = cnt_t'(NBUF);
          state_d     = S_IDLE;
        end
      end
      // A pending descriptor (sop+eop word that hit an open buffer) owns the next output slot.
      S_IDLE:  in_ready = (count_q != '0) && !pend_q.valid;
      S_OPEN:  in_ready = !in_sop || (count_q != '0);
      default: ;
    endcase

    accept = in_valid && in_ready;

    if (accept) begin
      if (state_q == S_IDLE || in_sop) begin
        pop      = 1'b1;
        word_ptr = fl_mem[head_q];
        word_lsb = '0;
        word_sop = in_sop;
      end
      if (state_q == S_IDLE && !in_sop)
        err_protocol_d = 1'b1;
      // sop on an open buffer: close it short and restart with this word.
      if (state_q == S_OPEN && in_sop) begin
        err_protocol_d = 1'b1;
        desc_d = '{valid: 1'b1, ptr: cur_ptr_q, sop: buf_sop_q, eop: 1'b0, last_lsb: lsb_q};
      end

      wr_valid_d = 1'b1;
      wr_ptr_d   = word_ptr;
      wr_lsb_d   = word_lsb;
      wr_data_d  = in_data;
      cur_ptr_d  = word_ptr;
      lsb_d      = word_lsb;
      buf_sop_d  = word_sop;

      if (in_eop || word_lsb == '1) begin
        closing = '{valid: 1'b1, ptr: word_ptr, sop: word_sop, eop: in_eop, last_lsb: word_lsb};
        if (desc_d.valid) pend_d = closing;
        else              desc_d = closing;
        state_d = S_IDLE;
      end else begin
        state_d = S_OPEN;
      end
    end

    // A full list still accepts a release when a pop frees the slot in the same cycle.
    if (state_q != S_INIT && rel_buf_valid) begin
      if (count_q == cnt_t'(NBUF) && !pop) begin
        err_overflow_d = 1'b1;
      end else begin
        push     = 1'b1;
        fl_we    = 1'b1;
        fl_waddr = tail_q;
        fl_wdata = rel_buf_ptr;
        tail_d   = ptr_t'(tail_q + 1'b1);
      end
    end

    if (pop) head_d = ptr_t'(head_q + 1'b1);
    if (pop && !push)      count_d = cnt_t'(count_q - 1'b1);
    else if (push && !pop) count_d = cnt_t'(count_q + 1'b1);
  end

  // NOTE: the free-list storage has no reset; the INIT sweep rewrites every slot after each reset.
  always_ff @(posedge clk) begin
    if (fl_we) fl_mem[fl_waddr] <= fl_wdata;
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_INIT;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      init_done_q    <= 1'b0;
      cur_ptr_q      <= '0;
      lsb_q          <= '0;
      buf_sop_q      <= 1'b0;
      wr_valid_q     <= 1'b0;
      wr_ptr_q       <= '0;
      wr_lsb_q       <= '0;
      wr_data_q      <= '0;
      desc_q         <= '0;
      pend_q         <= '0;
      err_protocol_q <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      init_done_q    <= init_done_d;
      cur_ptr_q      <= cur_ptr_d;
      lsb_q          <= lsb_d;
      buf_sop_q      <= buf_sop_d;
      wr_valid_q     <= wr_valid_d;
      wr_ptr_q       <= wr_ptr_d;
      wr_lsb_q       <= wr_lsb_d;
      wr_data_q      <= wr_data_d;
      desc_q         <= desc_d;
      pend_q         <= pend_d;
      err_protocol_q <= err_protocol_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign write_data_valid  = wr_valid_q;
  assign write_buf_ptr     = wr_ptr_q;
  assign write_buf_ptr_lsb = wr_lsb_q;
  assign write_data        = wr_data_q;
  assign desc_valid        = desc_q.valid;
  assign desc_buf_ptr      = desc_q.ptr;
  assign desc_sop          = desc_q.sop;
  assign desc_eop          = desc_q.eop;
  assign desc_last_lsb     = desc_q.last_lsb;
  assign free_count        = count_q;
  assign init_done         = init_done_q;
  assign err_protocol      = err_protocol_q;
  assign err_overflow      = err_overflow_q;

endmodule
